// File: rtl/uart_stream_checker.sv
// uart_stream_checker: receives frames from a monitored UART line, compares
// each against an expected-word FIFO and reports sticky pass/fail with a code.
module uart_stream_checker #(
  parameter int CLKS_PER_BIT   = 104,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int EXP_DEPTH      = 16,
  parameter int QUIET_CYCLES   = 10000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_uart_rx,
  input  logic                 i_exp_valid,
  input  logic [DATA_BITS-1:0] i_exp_data,
  output logic                 o_exp_ready,
  input  logic                 i_exp_done,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic [15:0]          o_match_count,
  output logic                 o_pass,
  output logic                 o_fail,
  output logic [2:0]           o_fail_code
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(EXP_DEPTH);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(EXP_DEPTH);
  localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYCLES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CHECK
  } state_t;

  state_t               state, state_n;
  logic                 sync1, rx_s, rx_prev;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err, frm_err;
  logic [DATA_BITS-1:0] mem [EXP_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [QW-1:0]        qcnt;
  logic [TW-1:0]        tcnt;

  logic       tick, start_edge, fifo_empty, fifo_full, pop, push_ok, overflow;
  logic       running, timeout_hit, pass_start, pass_cond;
  logic [2:0] chk_code, fail_req_code;

  assign tick        = (cnt == '0);
  assign start_edge  = rx_prev && !rx_s;
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == FIFO_FULL);
  assign pop         = (state == S_CHECK) && !fifo_empty;
  // Pop is applied before push, so a full FIFO still accepts during CHECK.
  assign push_ok     = i_exp_valid && (!fifo_full || pop);
  assign overflow    = i_exp_valid && fifo_full && !pop;
  assign o_exp_ready = !fifo_full;
  assign o_rx_valid  = (state == S_CHECK);
  assign running     = !fifo_empty && !o_fail;
  assign timeout_hit = running && (tcnt == TMO_LAST);
  assign pass_start  = o_pass && (state == S_IDLE) && start_edge;
  assign pass_cond   = (qcnt == QUIET_MAX) && i_exp_done && fifo_empty;

  // Two-flop synchroniser plus previous-value flop for falling-edge detect
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= i_uart_rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start_edge) state_n = S_START;
      S_START:  if (tick) state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_idx == DATA_LAST)
                  state_n = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_n = S_STOP;
      S_STOP:   if (tick && bit_idx == STOP_LAST) state_n = S_CHECK;
      S_CHECK:  state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Bit timing, shift register and per-frame error capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      o_rx_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_edge) begin
          cnt     <= CNT_HALF;
          bit_idx <= '0;
          par_err <= 1'b0;
          frm_err <= 1'b0;
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          cnt <= tick ? CNT_FULL : cnt - 1'b1;
          if (tick && state == S_DATA) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= (bit_idx == DATA_LAST) ? '0 : bit_idx + 1'b1;
          end
          if (tick && state == S_PARITY)
            par_err <= ((^shreg) ^ rx_s) != (PARITY == 1);
          if (tick && state == S_STOP) begin
            if (!rx_s) frm_err <= 1'b1;
            bit_idx <= (bit_idx == STOP_LAST) ? '0 : bit_idx + 1'b1;
            if (bit_idx == STOP_LAST) o_rx_data <= shreg;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame verdict and failure-cause arbitration
  always_comb begin
    chk_code = 3'd0;
    if (frm_err)                  chk_code = 3'd3;
    else if (par_err)             chk_code = 3'd4;
    else if (fifo_empty)          chk_code = 3'd2;
    else if (shreg != mem[rd_ptr]) chk_code = 3'd1;
    fail_req_code = 3'd0;
    if (state == S_CHECK && chk_code != 3'd0) fail_req_code = chk_code;
    else if (overflow)                        fail_req_code = 3'd6;
    else if (timeout_hit)                     fail_req_code = 3'd5;
    else if (pass_start)                      fail_req_code = 3'd2;
  end

  // Expected-word FIFO
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= i_exp_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  // Quiet and timeout counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      qcnt <= '0;
      tcnt <= '0;
    end else begin
      if (state == S_IDLE && rx_s) qcnt <= (qcnt == QUIET_MAX) ? qcnt : qcnt + 1'b1;
      else                         qcnt <= '0;
      if (!running || state == S_CHECK) tcnt <= '0;
      else                              tcnt <= tcnt + 1'b1;
    end
  end

  // Match counter and sticky pass/fail status
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_match_count <= '0;
      o_pass        <= 1'b0;
      o_fail        <= 1'b0;
      o_fail_code   <= '0;
    end else begin
      if (state == S_CHECK && chk_code == 3'd0 && o_match_count != 16'hFFFF)
        o_match_count <= o_match_count + 1'b1;
      if (!o_fail && fail_req_code != 3'd0) begin
        o_fail      <= 1'b1;
        o_fail_code <= fail_req_code;
        o_pass      <= 1'b0;
      end else if (!o_fail && pass_cond) begin
        o_pass <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_stream_checker.sv
// Directed bench for uart_stream_checker: three instances share stimulus
// (8N1 depth 16, 8E1, 8N2 depth 4), each scenario checks the relevant one.
module tb_uart_stream_checker;

  logic       clk = 1'b0;
  logic       rst, rx, exp_valid, exp_done;
  logic [7:0] exp_data;

  logic       a_ready, a_valid, a_pass, a_fail;
  logic [7:0] a_data;
  logic [15:0] a_match;
  logic [2:0] a_code;
  logic       b_ready, b_valid, b_pass, b_fail;
  logic [7:0] b_data;
  logic [15:0] b_match;
  logic [2:0] b_code;
  logic       c_ready, c_valid, c_pass, c_fail;
  logic [7:0] c_data;
  logic [15:0] c_match;
  logic [2:0] c_code;

  int checks = 0;
  int errors = 0;
  int va = 0;

  always #5 clk = ~clk;

  uart_stream_checker #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .EXP_DEPTH(16), .QUIET_CYCLES(64), .TIMEOUT_CYCLES(2000)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx), .i_exp_valid(exp_valid),
    .i_exp_data(exp_data), .o_exp_ready(a_ready), .i_exp_done(exp_done),
    .o_rx_valid(a_valid), .o_rx_data(a_data), .o_match_count(a_match),
    .o_pass(a_pass), .o_fail(a_fail), .o_fail_code(a_code));

  uart_stream_checker #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
    .EXP_DEPTH(16), .QUIET_CYCLES(64), .TIMEOUT_CYCLES(2000)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx), .i_exp_valid(exp_valid),
    .i_exp_data(exp_data), .o_exp_ready(b_ready), .i_exp_done(exp_done),
    .o_rx_valid(b_valid), .o_rx_data(b_data), .o_match_count(b_match),
    .o_pass(b_pass), .o_fail(b_fail), .o_fail_code(b_code));

  uart_stream_checker #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2),
    .EXP_DEPTH(4), .QUIET_CYCLES(64), .TIMEOUT_CYCLES(2000)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx), .i_exp_valid(exp_valid),
    .i_exp_data(exp_data), .o_exp_ready(c_ready), .i_exp_done(exp_done),
    .o_rx_valid(c_valid), .o_rx_data(c_data), .o_match_count(c_match),
    .o_pass(c_pass), .o_fail(c_fail), .o_fail_code(c_code));

  // Count received-frame pulses on instance A since the last reset
  always @(posedge clk) begin
    if (rst) va <= 0;
    else if (a_valid) va <= va + 1;
  end

  task do_reset();
    rx = 1'b1; exp_valid = 1'b0; exp_done = 1'b0; exp_data = 8'h00;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task push(input logic [7:0] d);
    @(negedge clk) begin exp_valid = 1'b1; exp_data = d; end
    @(negedge clk) exp_valid = 1'b0;
  endtask

  task send_bit(input logic b);
    rx = b;
    repeat (4) @(negedge clk);
  endtask

  task uart_send(input logic [7:0] d, input bit use_par, input logic pbit,
                 input int nstop, input logic last_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (use_par) send_bit(pbit);
    for (int s = 0; s < nstop; s++) send_bit((s == nstop - 1) ? last_stop : 1'b1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task test_reset();
    do_reset();
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", a_ready); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a_valid); end
    checks++; if ({a_pass, a_fail, a_code} !== 5'b0) begin errors++; $display("FAIL reset_status got %b want 00000", {a_pass, a_fail, a_code}); end
    checks++; if ({a_data, a_match} !== 24'h0) begin errors++; $display("FAIL reset_data_match got %h want 000000", {a_data, a_match}); end
  endtask

  task test_match_pass();
    do_reset();
    push(8'h55); push(8'hA3); push(8'h00);
    exp_done = 1'b1;
    uart_send(8'h55, 0, 1'b0, 1, 1'b1);
    uart_send(8'hA3, 0, 1'b0, 1, 1'b1);
    uart_send(8'h00, 0, 1'b0, 1, 1'b1);
    checks++; if (va !== 3) begin errors++; $display("FAIL match_pulses got %0d want 3", va); end
    checks++; if (a_match !== 16'd3) begin errors++; $display("FAIL match_count got %0d want 3", a_match); end
    checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL pass_early got %b want 0", a_pass); end
    repeat (72) @(negedge clk);
    checks++; if ({a_pass, a_fail} !== 2'b10) begin errors++; $display("FAIL pass_reached got %b want 10", {a_pass, a_fail}); end
  endtask

  task test_mismatch();
    do_reset();
    push(8'h41);
    uart_send(8'h42, 0, 1'b0, 1, 1'b1);
    checks++; if ({a_fail, a_code} !== 4'b1001) begin errors++; $display("FAIL mismatch_code got %b want 1001", {a_fail, a_code}); end
    checks++; if (a_data !== 8'h42) begin errors++; $display("FAIL mismatch_data got %h want 42", a_data); end
    push(8'h41);
    uart_send(8'h41, 0, 1'b0, 1, 1'b1);
    checks++; if (a_code !== 3'd1) begin errors++; $display("FAIL mismatch_sticky got %0d want 1", a_code); end
    checks++; if (va !== 2) begin errors++; $display("FAIL mismatch_pulses got %0d want 2", va); end
  endtask

  task test_unwanted();
    do_reset();
    uart_send(8'h7E, 0, 1'b0, 1, 1'b1);
    checks++; if ({a_fail, a_code} !== 4'b1010) begin errors++; $display("FAIL unwanted_code got %b want 1010", {a_fail, a_code}); end
    do_reset();
    exp_done = 1'b1;
    repeat (80) @(negedge clk);
    checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL idle_pass got %b want 1", a_pass); end
    uart_send(8'h33, 0, 1'b0, 1, 1'b1);
    checks++; if ({a_pass, a_fail, a_code} !== 5'b01010) begin errors++; $display("FAIL after_pass got %b want 01010", {a_pass, a_fail, a_code}); end
  endtask

  task test_parity_framing();
    do_reset();
    push(8'h07);
    uart_send(8'h07, 1, 1'b1, 1, 1'b1);
    checks++; if ({b_fail, b_match} !== 17'd1) begin errors++; $display("FAIL parity_good got %h want 00001", {b_fail, b_match}); end
    push(8'h03);
    uart_send(8'h03, 1, 1'b1, 1, 1'b1);
    checks++; if ({b_fail, b_code} !== 4'b1100) begin errors++; $display("FAIL parity_err got %b want 1100", {b_fail, b_code}); end
    do_reset();
    push(8'h5C);
    uart_send(8'h5C, 0, 1'b0, 2, 1'b0);
    checks++; if ({c_fail, c_code} !== 4'b1011) begin errors++; $display("FAIL framing_err got %b want 1011", {c_fail, c_code}); end
    checks++; if (c_data !== 8'h5C) begin errors++; $display("FAIL framing_data got %h want 5c", c_data); end
  endtask

  task test_timeout_overflow();
    do_reset();
    push(8'h10);
    repeat (1985) @(negedge clk);
    checks++; if (a_fail !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", a_fail); end
    repeat (30) @(negedge clk);
    checks++; if ({a_fail, a_code} !== 4'b1101) begin errors++; $display("FAIL timeout_code got %b want 1101", {a_fail, a_code}); end
    do_reset();
    push(8'h01); push(8'h02); push(8'h03);
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL ready_at3 got %b want 1", c_ready); end
    push(8'h04);
    checks++; if ({c_ready, c_fail} !== 2'b00) begin errors++; $display("FAIL full_at4 got %b want 00", {c_ready, c_fail}); end
    push(8'h05);
    checks++; if ({c_fail, c_code} !== 4'b1110) begin errors++; $display("FAIL overflow_code got %b want 1110", {c_fail, c_code}); end
  endtask

  task test_glitch_reset();
    do_reset();
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if ({va[3:0], a_fail} !== 5'b0) begin errors++; $display("FAIL glitch got pulses=%0d fail=%b want 0 0", va, a_fail); end
    push(8'h11);
    uart_send(8'h11, 0, 1'b0, 1, 1'b1);
    push(8'h22);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk) begin rx = 1'b1; rst = 1'b1; end
    @(negedge clk) rst = 1'b0;
    checks++; if ({a_match, a_data, a_valid, a_ready, a_fail, a_pass} !== {24'h0, 4'b0100}) begin
      errors++; $display("FAIL mid_frame_reset got %h want 0000004", {a_match, a_data, a_valid, a_ready, a_fail, a_pass}); end
    repeat (20) @(negedge clk);
    push(8'h5A);
    uart_send(8'h5A, 0, 1'b0, 1, 1'b1);
    checks++; if ({a_match, a_fail, a_data} !== {16'd1, 1'b0, 8'h5A}) begin
      errors++; $display("FAIL post_reset_match got match=%0d fail=%b data=%h want 1 0 5a", a_match, a_fail, a_data); end
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; exp_valid = 1'b0; exp_done = 1'b0; exp_data = 8'h00;
    test_reset();
    test_match_pass();
    test_mismatch();
    test_unwanted();
    test_parity_framing();
    test_timeout_overflow();
    test_glitch_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
